fwd_hazard_unit: RTL

// - Parametrised forwarding + load-use hazard unit for the pipelined CPU (successor to forwarding_unit).
// - Tracks the destination of each in-flight instruction through the EX, MEM and WB stages in internal shadow registers.
// - Drives per-operand EX forwarding mux selects for NUM_SRC operands.
// - Raises a one-cycle load-use stall and counts stall cycles.

---
 rtl/fwd_hazard_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the pipelined CPU. Internal shadow
//   registers follow each in-flight instruction's destination through EX, MEM
//   and WB. From that state the unit produces the per-operand EX forwarding
//   mux selects and a one-cycle load-use stall, and it keeps a saturating
//   count of stall cycles.
//
//   Optional feature: define ZERO_REG_EN to hardwire r0 to zero. With it
//   defined, r0 never matches, so it never forwards and never stalls.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous, active-high reset
//   i_id_valid     instruction in ID is real (not a bubble)
//   i_id_rs        ID source registers, operand i at [i*AW +: AW]
//   i_id_rd        ID destination register
//   i_id_regwrite  ID instruction writes the register file
//   i_id_memread   ID instruction is a load
//   i_flush        kill the ID and EX instructions (branch taken)
//   o_ex_fwd_sel   per operand: 00 regfile, 01 WB result, 10 MEM result
//   o_stall        hold PC and IF/ID, insert a bubble into EX
//   o_stall_cnt    saturating count of stall cycles
// ---------------------------------------------------------------------------

// Per-operand lane: computes the forward select and the load-use hit for a
// single operand.
module fwd_hazard_lane #(
    parameter int AW = 3
) (
    input  logic [AW-1:0] i_id_rs,
    input  logic [AW-1:0] i_ex_rs,
    input  logic          i_ex_vld,
    input  logic [AW-1:0] i_ex_rd,
    input  logic          i_mem_vld,
    input  logic          i_mem_rw,
    input  logic          i_mem_ld,
    input  logic [AW-1:0] i_mem_rd,
    input  logic          i_wb_vld,
    input  logic          i_wb_rw,
    input  logic [AW-1:0] i_wb_rd,
    output logic [1:0]    o_sel,
    output logic          o_ld_hit
);
    function automatic logic f_match(input logic [AW-1:0] rd, input logic [AW-1:0] rs);
`ifdef ZERO_REG_EN
        return (rd == rs) && (rd != '0);
`else
        return (rd == rs);
`endif
    endfunction

    // A load in MEM never forwards. The load-use stall makes sure the
    // consumer only reaches EX once the load has moved on to WB.
    always_comb begin
        o_sel = 2'b00;
        if (i_ex_vld) begin
            if (i_mem_vld && i_mem_rw && !i_mem_ld && f_match(i_mem_rd, i_ex_rs))
                o_sel = 2'b10;
            else if (i_wb_vld && i_wb_rw && f_match(i_wb_rd, i_ex_rs))
                o_sel = 2'b01;
        end
    end

    // The caller gates this with the EX valid/regwrite/load qualifiers.
    assign o_ld_hit = f_match(i_ex_rd, i_id_rs);
endmodule

module fwd_hazard_unit #(
    parameter int AW      = 3,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_id_valid,
    input  logic [NUM_SRC*AW-1:0] i_id_rs,
    input  logic [AW-1:0]         i_id_rd,
    input  logic                  i_id_regwrite,
    input  logic                  i_id_memread,
    input  logic                  i_flush,
    output logic [NUM_SRC*2-1:0]  o_ex_fwd_sel,
    output logic                  o_stall,
    output logic [CNT_W-1:0]      o_stall_cnt
);
    typedef struct packed {
        logic          rw;
        logic          ld;
        logic [AW-1:0] rd;
    } ent_t;

    // Valid bits per stage: [0]=EX, [1]=MEM, [2]=WB.
    logic [2:0]                   r_vld_pipe;
    ent_t                         r_ex, r_mem, r_wb;
    logic [NUM_SRC-1:0][AW-1:0]   r_ex_rs;
    logic [CNT_W-1:0]             r_cnt;
    logic [NUM_SRC-1:0]           w_ld_hit;
    logic                         w_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        fwd_hazard_lane #(.AW(AW)) u_lane (
            .i_id_rs   (i_id_rs[g*AW +: AW]),
            .i_ex_rs   (r_ex_rs[g]),
            .i_ex_vld  (r_vld_pipe[0]),
            .i_ex_rd   (r_ex.rd),
            .i_mem_vld (r_vld_pipe[1]),
            .i_mem_rw  (r_mem.rw),
            .i_mem_ld  (r_mem.ld),
            .i_mem_rd  (r_mem.rd),
            .i_wb_vld  (r_vld_pipe[2]),
            .i_wb_rw   (r_wb.rw),
            .i_wb_rd   (r_wb.rd),
            .o_sel     (o_ex_fwd_sel[g*2 +: 2]),
            .o_ld_hit  (w_ld_hit[g])
        );
    end

    // Flush overrides the stall: the consumer being held is killed anyway.
    assign w_stall = i_id_valid & r_vld_pipe[0] & r_ex.rw & r_ex.ld & (|w_ld_hit) & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb       <= '0;
            r_ex_rs    <= '0;
            r_cnt      <= '0;
        end else begin
            r_vld_pipe[2] <= r_vld_pipe[1];
            r_wb          <= r_mem;

            if (i_flush) begin
                r_vld_pipe[1] <= 1'b0;
                r_mem         <= '0;
            end else begin
                r_vld_pipe[1] <= r_vld_pipe[0];
                r_mem         <= r_ex;
            end

            if (i_flush || w_stall) begin
                r_vld_pipe[0] <= 1'b0;
                r_ex          <= '0;
                r_ex_rs       <= '0;
            end else begin
                r_vld_pipe[0] <= i_id_valid;
                r_ex          <= '{rw: i_id_regwrite, ld: i_id_memread, rd: i_id_rd};
                r_ex_rs       <= i_id_rs;
            end

            if (w_stall && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_stall     = w_stall;
    assign o_stall_cnt = r_cnt;
endmodule
